return_reorder_buffer: RTL and testbench

- Sits directly upstream of the TX-controller returner.
- Assigns an in-order 6-bit tag to every read/write request as it is issued to memory.
- Accepts memory completions out of order by tag, holds read data, and presents completions strictly in issue order on a valid/ready port.
- The returner consumes that port to raise read_done/write_done and drive returned data.

---
 rtl/ret_pkg.sv | 14 +
 rtl/ret_data_ram.sv | 20 ++
 rtl/return_reorder_buffer.sv | 96 +++++++++
 tb/tb_return_reorder_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ret_pkg.sv
// Shared sizing and entry layout for the return reorder buffer and the returner.
package ret_pkg;
    localparam int DEPTH = 64;
    localparam int TAG_W = 6;
    localparam int PTR_W = 7;

    // Bit offsets of the per-entry fields when an entry is viewed as one flat word.
    localparam int ENT_ALLOC    = 0;
    localparam int ENT_DONE     = 1;
    localparam int ENT_IS_WRITE = 2;
    localparam int ENT_DATA     = 3;

    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_e;
endpackage

// File: rtl/ret_data_ram.sv
// Completion data store: synchronous write on completion, asynchronous read at head.
module ret_data_ram #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/return_reorder_buffer.sv
// In-order tag allocator that accepts out-of-order completions and returns
// them strictly in issue order on a valid/ready port.
module return_reorder_buffer
    import ret_pkg::*;
#(
    parameter int data_width = 31,
    parameter int depth_log2 = TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic                  alloc_is_write,
    output logic                  alloc_ready,
    output logic [depth_log2-1:0] alloc_tag,
    input  logic                  cmp_valid,
    input  logic [depth_log2-1:0] cmp_tag,
    input  logic [data_width:0]   cmp_data,
    output logic                  ret_valid,
    output logic                  ret_is_write,
    output logic [data_width:0]   ret_data,
    input  logic                  ret_ready,
    output logic [depth_log2:0]   occupancy,
    output logic                  cmp_err
);
    localparam int N  = 1 << depth_log2;
    localparam int PW = depth_log2 + 1;

    logic [PW-1:0] r_head, r_tail, r_occ;
    logic [N-1:0]  r_alloc, r_done, r_is_wr;
    logic          r_cmp_err;

    logic [depth_log2-1:0] w_head_idx, w_tail_idx;
    logic                  w_full, w_alloc_fire, w_pop, w_cmp_ok;
    logic [data_width:0]   w_wdata;

    assign w_head_idx = r_head[depth_log2-1:0];
    assign w_tail_idx = r_tail[depth_log2-1:0];
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[PW-1] != r_tail[PW-1]);

    // Ready comes from registered state only, so a pop never frees a slot in the same cycle.
    assign w_alloc_fire = alloc_valid & ~w_full;
    assign w_pop        = ret_valid & ret_ready;
    assign w_cmp_ok     = cmp_valid & r_alloc[cmp_tag] & ~r_done[cmp_tag]
                        & ~(w_alloc_fire & (cmp_tag == w_tail_idx));
    assign w_wdata      = r_is_wr[cmp_tag] ? '0 : cmp_data;

    ret_data_ram #(.DW(data_width + 1), .AW(depth_log2)) u_ram (
        .clk     (clk),
        .i_we    (w_cmp_ok),
        .i_waddr (cmp_tag),
        .i_wdata (w_wdata),
        .i_raddr (w_head_idx),
        .o_rdata (ret_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_occ     <= '0;
            r_alloc   <= '0;
            r_done    <= '0;
            r_cmp_err <= 1'b0;
        end else begin
            // Alloc, completion and pop always hit distinct entries.
            if (w_alloc_fire) begin
                r_alloc[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_tail              <= r_tail + 1'b1;
            end
            if (w_cmp_ok) r_done[cmp_tag] <= 1'b1;
            if (w_pop) begin
                r_alloc[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            case ({w_alloc_fire, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            r_cmp_err <= cmp_valid & ~w_cmp_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_fire) r_is_wr[w_tail_idx] <= alloc_is_write;
    end

    assign alloc_ready  = ~w_full;
    assign alloc_tag    = w_tail_idx;
    assign ret_valid    = r_alloc[w_head_idx] & r_done[w_head_idx];
    assign ret_is_write = r_is_wr[w_head_idx];
    assign occupancy    = r_occ;
    assign cmp_err      = r_cmp_err;
endmodule

// File: tb/tb_return_reorder_buffer.sv
// Directed bench for return_reorder_buffer: ordering, full/wrap, illegal
// completions, back-pressure, simultaneous events and mid-run reset.
module tb_return_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0, alloc_is_write = 1'b0, alloc_ready;
    logic [5:0]  alloc_tag;
    logic        cmp_valid = 1'b0;
    logic [5:0]  cmp_tag = '0;
    logic [31:0] cmp_data = '0;
    logic        ret_valid, ret_is_write, ret_ready = 1'b0;
    logic [31:0] ret_data;
    logic [6:0]  occupancy;
    logic        cmp_err;

    int n_pass = 0;
    int n_total = 0;

    return_reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_is_write(alloc_is_write),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
        .ret_valid(ret_valid), .ret_is_write(ret_is_write), .ret_data(ret_data),
        .ret_ready(ret_ready), .occupancy(occupancy), .cmp_err(cmp_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid = 0; cmp_valid = 0; ret_ready = 0; rst = 0;
        tick(); tick();
        rst = 1;
    endtask

    task automatic alloc_n(input int n, input logic wr);
        alloc_valid = 1; alloc_is_write = wr;
        repeat (n) tick();
        alloc_valid = 0; alloc_is_write = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (ret_valid !== 1'b0) $display("FAIL reset_ret_valid got %0b want 0", ret_valid); else n_pass++;
        n_total++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %0b want 1", alloc_ready); else n_pass++;
        n_total++; if (alloc_tag !== 6'd0) $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag); else n_pass++;
        n_total++; if (occupancy !== 7'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else n_pass++;
        n_total++; if (cmp_err !== 1'b0) $display("FAIL reset_cmp_err got %0b want 0", cmp_err); else n_pass++;
    endtask

    task automatic test_in_order();
        do_reset();
        alloc_n(1, 0); alloc_n(1, 1); alloc_n(1, 0);
        n_total++; if (occupancy !== 7'd3) $display("FAIL order_occ got %0d want 3", occupancy); else n_pass++;
        ret_ready = 1;
        cmp_valid = 1; cmp_tag = 2; cmp_data = 32'hCAFE0002; tick();
        n_total++; if (ret_valid !== 1'b0) $display("FAIL order_early_tag2 got %0b want 0", ret_valid); else n_pass++;
        cmp_tag = 1; cmp_data = 32'h12345678; tick();
        n_total++; if (ret_valid !== 1'b0) $display("FAIL order_early_tag1 got %0b want 0", ret_valid); else n_pass++;
        cmp_tag = 0; cmp_data = 32'hCAFE0000; tick();
        cmp_valid = 0;
        n_total++; if (ret_valid !== 1'b1 || ret_is_write !== 1'b0 || ret_data !== 32'hCAFE0000)
            $display("FAIL order_ret0 got v=%0b w=%0b d=%h want v=1 w=0 d=cafe0000", ret_valid, ret_is_write, ret_data); else n_pass++;
        tick();
        n_total++; if (ret_valid !== 1'b1 || ret_is_write !== 1'b1 || ret_data !== 32'h0)
            $display("FAIL order_ret1 got v=%0b w=%0b d=%h want v=1 w=1 d=0", ret_valid, ret_is_write, ret_data); else n_pass++;
        tick();
        n_total++; if (ret_valid !== 1'b1 || ret_is_write !== 1'b0 || ret_data !== 32'hCAFE0002)
            $display("FAIL order_ret2 got v=%0b w=%0b d=%h want v=1 w=0 d=cafe0002", ret_valid, ret_is_write, ret_data); else n_pass++;
        tick();
        ret_ready = 0;
        n_total++; if (ret_valid !== 1'b0 || occupancy !== 7'd0)
            $display("FAIL order_drained got v=%0b occ=%0d want v=0 occ=0", ret_valid, occupancy); else n_pass++;
    endtask

    task automatic test_full_wrap();
        do_reset();
        alloc_n(64, 0);
        n_total++; if (alloc_ready !== 1'b0 || occupancy !== 7'd64 || alloc_tag !== 6'd0)
            $display("FAIL full_state got rdy=%0b occ=%0d tag=%0d want rdy=0 occ=64 tag=0", alloc_ready, occupancy, alloc_tag); else n_pass++;
        alloc_n(1, 0);
        n_total++; if (occupancy !== 7'd64) $display("FAIL full_alloc_blocked got occ=%0d want 64", occupancy); else n_pass++;
        cmp_valid = 1; cmp_tag = 0; cmp_data = 32'h000000A0; tick();
        cmp_valid = 0;
        n_total++; if (ret_valid !== 1'b1 || ret_data !== 32'hA0)
            $display("FAIL full_head_ret got v=%0b d=%h want v=1 d=a0", ret_valid, ret_data); else n_pass++;
        ret_ready = 1; alloc_valid = 1; tick();
        ret_ready = 0; alloc_valid = 0;
        n_total++; if (alloc_ready !== 1'b1 || occupancy !== 7'd63 || alloc_tag !== 6'd0 || ret_valid !== 1'b0)
            $display("FAIL full_pop_no_bypass got rdy=%0b occ=%0d tag=%0d v=%0b want rdy=1 occ=63 tag=0 v=0",
                     alloc_ready, occupancy, alloc_tag, ret_valid); else n_pass++;
        alloc_n(1, 0);
        n_total++; if (alloc_ready !== 1'b0 || occupancy !== 7'd64 || alloc_tag !== 6'd1)
            $display("FAIL full_wrap got rdy=%0b occ=%0d tag=%0d want rdy=0 occ=64 tag=1", alloc_ready, occupancy, alloc_tag); else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        alloc_n(1, 0);
        cmp_valid = 1; cmp_tag = 5; cmp_data = 32'hBAD5; tick();
        cmp_valid = 0;
        n_total++; if (cmp_err !== 1'b1 || ret_valid !== 1'b0 || occupancy !== 7'd1)
            $display("FAIL ill_unalloc got err=%0b v=%0b occ=%0d want err=1 v=0 occ=1", cmp_err, ret_valid, occupancy); else n_pass++;
        tick();
        n_total++; if (cmp_err !== 1'b0) $display("FAIL ill_pulse_width got %0b want 0", cmp_err); else n_pass++;
        cmp_valid = 1; cmp_tag = 0; cmp_data = 32'h55; tick();
        n_total++; if (cmp_err !== 1'b0 || ret_valid !== 1'b1 || ret_data !== 32'h55)
            $display("FAIL ill_first_ok got err=%0b v=%0b d=%h want err=0 v=1 d=55", cmp_err, ret_valid, ret_data); else n_pass++;
        cmp_data = 32'h66; tick();
        cmp_valid = 0;
        n_total++; if (cmp_err !== 1'b1 || ret_data !== 32'h55)
            $display("FAIL ill_double got err=%0b d=%h want err=1 d=55", cmp_err, ret_data); else n_pass++;
        ret_ready = 1; tick();
        ret_ready = 0;
        n_total++; if (ret_valid !== 1'b0 || occupancy !== 7'd0 || cmp_err !== 1'b0)
            $display("FAIL ill_single_ret got v=%0b occ=%0d err=%0b want v=0 occ=0 err=0", ret_valid, occupancy, cmp_err); else n_pass++;
        alloc_valid = 1; cmp_valid = 1; cmp_tag = 1; cmp_data = 32'h77; tick();
        alloc_valid = 0; cmp_valid = 0;
        n_total++; if (cmp_err !== 1'b1 || ret_valid !== 1'b0 || occupancy !== 7'd1)
            $display("FAIL ill_same_cycle got err=%0b v=%0b occ=%0d want err=1 v=0 occ=1", cmp_err, ret_valid, occupancy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_n(4, 0);
        cmp_valid = 1; cmp_tag = 0; cmp_data = 32'hD0; tick();
        cmp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (ret_valid !== 1'b1 || ret_data !== 32'hD0)
                $display("FAIL stall_hold_%0d got v=%0b d=%h want v=1 d=d0", i, ret_valid, ret_data); else n_pass++;
            tick();
        end
        ret_ready = 1; alloc_valid = 1; cmp_valid = 1; cmp_tag = 3; cmp_data = 32'hD3; tick();
        ret_ready = 0; alloc_valid = 0; cmp_valid = 0;
        n_total++; if (occupancy !== 7'd4 || alloc_tag !== 6'd5 || ret_valid !== 1'b0)
            $display("FAIL simul got occ=%0d tag=%0d v=%0b want occ=4 tag=5 v=0", occupancy, alloc_tag, ret_valid); else n_pass++;
        cmp_valid = 1; cmp_tag = 1; cmp_data = 32'hD1; tick();
        n_total++; if (ret_valid !== 1'b1 || ret_data !== 32'hD1)
            $display("FAIL b2b_ret1 got v=%0b d=%h want v=1 d=d1", ret_valid, ret_data); else n_pass++;
        ret_ready = 1; cmp_tag = 2; cmp_data = 32'hD2; tick();
        cmp_valid = 0;
        n_total++; if (ret_valid !== 1'b1 || ret_data !== 32'hD2)
            $display("FAIL b2b_ret2 got v=%0b d=%h want v=1 d=d2", ret_valid, ret_data); else n_pass++;
        tick();
        n_total++; if (ret_valid !== 1'b1 || ret_data !== 32'hD3)
            $display("FAIL b2b_ret3 got v=%0b d=%h want v=1 d=d3", ret_valid, ret_data); else n_pass++;
        tick();
        ret_ready = 0;
        n_total++; if (ret_valid !== 1'b0 || occupancy !== 7'd1)
            $display("FAIL b2b_tail got v=%0b occ=%0d want v=0 occ=1", ret_valid, occupancy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(10, 0);
        n_total++; if (occupancy !== 7'd10) $display("FAIL mid_occ got %0d want 10", occupancy); else n_pass++;
        rst = 0; tick();
        rst = 1;
        n_total++; if (occupancy !== 7'd0 || ret_valid !== 1'b0 || alloc_tag !== 6'd0)
            $display("FAIL mid_reset got occ=%0d v=%0b tag=%0d want occ=0 v=0 tag=0", occupancy, ret_valid, alloc_tag); else n_pass++;
        cmp_valid = 1; cmp_tag = 4; cmp_data = 32'h44; tick();
        cmp_valid = 0;
        n_total++; if (cmp_err !== 1'b1 || ret_valid !== 1'b0)
            $display("FAIL mid_stale_cmp got err=%0b v=%0b want err=1 v=0", cmp_err, ret_valid); else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
